// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    HUNT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    APPLY = 3'd4
  } state_t;

  localparam logic [5:0] PRESCALE_X1      = 6'd1;
  localparam logic [5:0] PRESCALE_X8      = 6'd8;
  localparam logic [5:0] PRESCALE_X16     = 6'd16;
  localparam logic [5:0] PRESCALE_X32     = 6'd32;
  localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_X32;

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == PRESCALE_X1) || (p == PRESCALE_X8) ||
           (p == PRESCALE_X16) || (p == PRESCALE_X32);
  endfunction

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// First-word-fall-through byte FIFO; push while full is accepted only alongside a pop.
module uart_rx_byte_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s;
  logic          pop_s;

  assign empty   = (count_r == {(AW+1){1'b0}});
  assign full    = (count_r == (AW+1)'(DEPTH));
  assign pop_s   = pop & ~empty;
  assign push_s  = push & (~full | pop_s);
  assign rd_data = empty ? 8'h00 : mem_r[rd_ptr_r];

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Sequences a UART receiver: gates the line, applies config only when idle,
// filters errored frames into a FIFO-backed stream and keeps error statistics.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int IDLE_CYCLES = 320,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  output logic             rx_line,
  output logic [5:0]       rx_prescale,
  output logic             rx_par_en,
  output logic             rx_par_typ,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_par_err,
  input  logic             rx_stp_err,
  input  logic             enable,
  input  logic             cfg_wr,
  input  logic [5:0]       cfg_prescale,
  input  logic             cfg_par_en,
  input  logic             cfg_par_typ,
  output logic             cfg_busy,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             ovf_flag
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);

  state_t           state_r;
  logic [IW-1:0]    idle_cnt_r;
  logic             idle_s;
  logic             rx_line_r;
  logic [5:0]       rx_prescale_r;
  logic             rx_par_en_r;
  logic             rx_par_typ_r;
  logic [5:0]       pend_prescale_r;
  logic             pend_par_en_r;
  logic             pend_par_typ_r;
  logic             cfg_busy_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] ovf_cnt_r;
  logic             ovf_flag_r;
  logic             err_prev_r;
  logic             err_s;
  logic             accept_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             err_inc_s;
  logic             ovf_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign idle_s   = (idle_cnt_r == IW'(IDLE_CYCLES));
  assign err_s    = rx_par_err | rx_stp_err;
  assign accept_s = rx_valid & ((state_r == RUN) | (state_r == DRAIN));
  assign pop_s    = ~empty_s & m_ready;

  // Consecutive-high counter on the raw line, restarted after a config apply.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idle_cnt_r <= {IW{1'b0}};
    end else if (state_r == APPLY || !RX_IN) begin
      idle_cnt_r <= {IW{1'b0}};
    end else if (!idle_s) begin
      idle_cnt_r <= idle_cnt_r + IW'(1);
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  // Controller FSM with line gating and pending/live configuration.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r         <= OFF;
      rx_line_r       <= 1'b1;
      rx_prescale_r   <= PRESCALE_DEFAULT;
      rx_par_en_r     <= 1'b0;
      rx_par_typ_r    <= 1'b0;
      pend_prescale_r <= PRESCALE_DEFAULT;
      pend_par_en_r   <= 1'b0;
      pend_par_typ_r  <= 1'b0;
      cfg_busy_r      <= 1'b0;
    end else begin
      rx_line_r <= (state_r == RUN || state_r == DRAIN) ? RX_IN : 1'b1;
      if (cfg_wr) begin
        pend_prescale_r <= cfg_prescale;
        pend_par_en_r   <= cfg_par_en;
        pend_par_typ_r  <= cfg_par_typ;
        cfg_busy_r      <= 1'b1;
      end
      case (state_r)
        OFF: begin
          if (enable) state_r <= HUNT;
        end
        HUNT: begin
          if (!enable)                  state_r <= OFF;
          else if (cfg_busy_r && idle_s) state_r <= APPLY;
          else if (idle_s)               state_r <= RUN;
        end
        RUN: begin
          if (!enable || cfg_busy_r) state_r <= DRAIN;
        end
        DRAIN: begin
          if (idle_s) state_r <= cfg_busy_r ? APPLY : OFF;
        end
        APPLY: begin
          rx_prescale_r <= pend_prescale_r;
          rx_par_en_r   <= pend_par_en_r;
          rx_par_typ_r  <= pend_par_typ_r;
          if (!cfg_wr) cfg_busy_r <= 1'b0;
          state_r <= HUNT;
        end
        default: state_r <= OFF;
      endcase
    end
  end

  // Classify each completed frame; error pulses without a frame count on their rising edge.
  always_comb begin
    err_inc_s = 1'b0;
    ovf_inc_s = 1'b0;
    push_s    = 1'b0;
    if (accept_s) begin
      if (err_s) begin
        err_inc_s = 1'b1;
      end else if (full_s && !pop_s) begin
        ovf_inc_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else if (!rx_valid && err_s && !err_prev_r) begin
      err_inc_s = 1'b1;
    end else begin
      err_inc_s = 1'b0;
    end
  end

  // Saturating statistics; a clear beats a same-cycle increment.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt_r  <= {CNT_W{1'b0}};
      ovf_cnt_r  <= {CNT_W{1'b0}};
      ovf_flag_r <= 1'b0;
      err_prev_r <= 1'b0;
    end else begin
      err_prev_r <= err_s;
      if (stat_clr) begin
        err_cnt_r  <= {CNT_W{1'b0}};
        ovf_cnt_r  <= {CNT_W{1'b0}};
        ovf_flag_r <= 1'b0;
      end else begin
        if (err_inc_s) err_cnt_r <= sat_inc(err_cnt_r);
        if (ovf_inc_s) begin
          ovf_cnt_r  <= sat_inc(ovf_cnt_r);
          ovf_flag_r <= 1'b1;
        end
      end
    end
  end

  uart_rx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (rx_data),
    .rd_data (m_data),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign m_valid     = ~empty_s;
  assign rx_line     = rx_line_r;
  assign rx_prescale = rx_prescale_r;
  assign rx_par_en   = rx_par_en_r;
  assign rx_par_typ  = rx_par_typ_r;
  assign cfg_busy    = cfg_busy_r;
  assign err_cnt     = err_cnt_r;
  assign ovf_cnt     = ovf_cnt_r;
  assign ovf_flag    = ovf_flag_r;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: table of frame vectors plus hand sequences.
module tb_uart_rx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST, RX_IN, rx_line;
  logic [5:0] rx_prescale;
  logic       rx_par_en, rx_par_typ;
  logic [7:0] rx_data;
  logic       rx_valid, rx_par_err, rx_stp_err, enable, cfg_wr;
  logic [5:0] cfg_prescale;
  logic       cfg_par_en, cfg_par_typ, cfg_busy;
  logic [7:0] m_data;
  logic       m_valid, m_ready, stat_clr;
  logic [7:0] err_cnt, ovf_cnt;
  logic       ovf_flag;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  uart_rx_frame_ctrl #(.DEPTH(4), .IDLE_CYCLES(320), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .rx_line(rx_line),
    .rx_prescale(rx_prescale), .rx_par_en(rx_par_en), .rx_par_typ(rx_par_typ),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_par_err(rx_par_err),
    .rx_stp_err(rx_stp_err), .enable(enable), .cfg_wr(cfg_wr),
    .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
    .cfg_busy(cfg_busy), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .stat_clr(stat_clr), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt), .ovf_flag(ovf_flag)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       perr;
    logic       serr;
    logic       ready;
    logic       clr;
    logic       exp_mv;
    logic [7:0] exp_md;
    logic [7:0] exp_err;
    logic [7:0] exp_ovf;
    logic       exp_flag;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  function automatic vec_t mkv(input logic v, input logic [7:0] d, input logic pe,
                               input logic se, input logic rdy, input logic clr,
                               input logic mv, input logic [7:0] md,
                               input logic [7:0] ec, input logic [7:0] oc, input logic fl);
    vec_t t;
    t.valid = v; t.data = d; t.perr = pe; t.serr = se; t.ready = rdy; t.clr = clr;
    t.exp_mv = mv; t.exp_md = md; t.exp_err = ec; t.exp_ovf = oc; t.exp_flag = fl;
    return t;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // From any enabled state with no pending config, wait out the idle hunt and confirm RUN.
  task automatic go_run(input string tag);
    RX_IN = 1'b1;
    repeat (330) tick();
    RX_IN = 1'b0;
    tick();
    tick();
    chk({tag, " rx_line follows"}, 32'(rx_line), 32'(1'b0));
    RX_IN = 1'b1;
    tick();
  endtask

  initial begin
    // frame vectors: valid data perr serr ready clr | m_valid m_data err ovf flag
    vt[0]  = mkv(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd0, 8'd0, 1'b0);
    vt[1]  = mkv(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd0, 8'd0, 1'b0);
    vt[2]  = mkv(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd0, 8'd0, 1'b0);
    vt[3]  = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 8'd0, 8'd0, 1'b0);
    vt[4]  = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd0, 8'd0, 1'b0);
    vt[5]  = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0, 1'b0);
    vt[6]  = mkv(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'd0, 8'd0, 1'b0);
    vt[7]  = mkv(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'd0, 8'd0, 1'b0);
    vt[8]  = mkv(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'd0, 8'd0, 1'b0);
    vt[9]  = mkv(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'd0, 8'd0, 1'b0);
    vt[10] = mkv(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'd0, 8'd1, 1'b1);
    vt[11] = mkv(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 8'd0, 8'd1, 1'b1);
    vt[12] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 8'd0, 8'd1, 1'b1);
    vt[13] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 8'd0, 8'd1, 1'b1);
    vt[14] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h66, 8'd0, 8'd1, 1'b1);
    vt[15] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 8'd1, 1'b1);
    vt[16] = mkv(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd1, 8'd1, 1'b1);
    vt[17] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd1, 8'd1, 1'b1);
    vt[18] = mkv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd2, 8'd1, 1'b1);
    vt[19] = mkv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd2, 8'd1, 1'b1);
    vt[20] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd2, 8'd1, 1'b1);
    vt[21] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 8'd0, 1'b0);
    vt[22] = mkv(1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 8'd0, 1'b0);
    vt[23] = mkv(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 8'd0, 8'd0, 1'b0);
    vt[24] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0, 1'b0);

    RST = 1'b1; RX_IN = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    rx_par_err = 1'b0; rx_stp_err = 1'b0; enable = 1'b0; cfg_wr = 1'b0;
    cfg_prescale = 6'd0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
    m_ready = 1'b0; stat_clr = 1'b0;
    tick();
    tick();
    chk("rst rx_line",     32'(rx_line),     32'(1'b1));
    chk("rst rx_prescale", 32'(rx_prescale), 32'(6'd32));
    chk("rst rx_par_en",   32'(rx_par_en),   32'(1'b0));
    chk("rst rx_par_typ",  32'(rx_par_typ),  32'(1'b0));
    chk("rst cfg_busy",    32'(cfg_busy),    32'(1'b0));
    chk("rst m_valid",     32'(m_valid),     32'(1'b0));
    chk("rst m_data",      32'(m_data),      32'(8'h00));
    chk("rst err_cnt",     32'(err_cnt),     32'(8'd0));
    chk("rst ovf_cnt",     32'(ovf_cnt),     32'(8'd0));
    chk("rst ovf_flag",    32'(ovf_flag),    32'(1'b0));

    // Idle hunt: RUN is entered on the 321st edge after reset release.
    RST = 1'b0; enable = 1'b1;
    repeat (320) tick();
    RX_IN = 1'b0;
    tick();
    chk("hunt line gated", 32'(rx_line), 32'(1'b1));
    tick();
    chk("run line follows", 32'(rx_line), 32'(1'b0));
    chk("run prescale", 32'(rx_prescale), 32'(6'd32));

    // Config request mid-frame: applied only after 320 idle cycles following the stop bit.
    tick();
    cfg_prescale = 6'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b1; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("cfg busy set", 32'(cfg_busy), 32'(1'b1));
    chk("cfg not yet live", 32'(rx_prescale), 32'(6'd32));
    for (int i = 0; i < 20; i++) begin
      RX_IN = ~i[0];
      tick();
    end
    RX_IN = 1'b1;
    repeat (320) tick();
    chk("drain prescale held", 32'(rx_prescale), 32'(6'd32));
    chk("drain par_en held",   32'(rx_par_en),   32'(1'b0));
    chk("drain busy held",     32'(cfg_busy),    32'(1'b1));
    tick();
    chk("enter apply prescale held", 32'(rx_prescale), 32'(6'd32));
    tick();
    chk("apply prescale", 32'(rx_prescale), 32'(6'd16));
    chk("apply par_en",   32'(rx_par_en),   32'(1'b1));
    chk("apply par_typ",  32'(rx_par_typ),  32'(1'b1));
    chk("apply busy clr", 32'(cfg_busy),    32'(1'b0));
    go_run("post-apply");

    // Table-driven frame handling in RUN.
    for (int i = 0; i < NV; i++) begin
      rx_valid = vt[i].valid; rx_data = vt[i].data; rx_par_err = vt[i].perr;
      rx_stp_err = vt[i].serr; m_ready = vt[i].ready; stat_clr = vt[i].clr;
      tick();
      chk($sformatf("v%0d m_valid", i),  32'(m_valid),  32'(vt[i].exp_mv));
      chk($sformatf("v%0d m_data", i),   32'(m_data),   32'(vt[i].exp_md));
      chk($sformatf("v%0d err_cnt", i),  32'(err_cnt),  32'(vt[i].exp_err));
      chk($sformatf("v%0d ovf_cnt", i),  32'(ovf_cnt),  32'(vt[i].exp_ovf));
      chk($sformatf("v%0d ovf_flag", i), 32'(ovf_flag), 32'(vt[i].exp_flag));
    end
    rx_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0; m_ready = 1'b0; stat_clr = 1'b0;

    // Error counter saturation and clear.
    for (int i = 0; i < 300; i++) begin
      rx_stp_err = 1'b1;
      tick();
      rx_stp_err = 1'b0;
      tick();
    end
    chk("err saturate", 32'(err_cnt), 32'(8'd255));
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("err clear", 32'(err_cnt), 32'(8'd0));

    // Disable drains to OFF without flushing the FIFO.
    rx_valid = 1'b1; rx_data = 8'hCC;
    tick();
    rx_valid = 1'b0; enable = 1'b0;
    repeat (3) tick();
    RX_IN = 1'b0;
    tick();
    tick();
    chk("off line gated", 32'(rx_line), 32'(1'b1));
    chk("off keeps m_valid", 32'(m_valid), 32'(1'b1));
    chk("off keeps m_data", 32'(m_data), 32'(8'hCC));
    enable = 1'b1;
    go_run("re-enable");

    // Reset mid-traffic with two bytes buffered and a pending config.
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hAA;
    tick();
    rx_data = 8'hBB;
    tick();
    rx_valid = 1'b0;
    chk("pre-rst head", 32'(m_data), 32'(8'hAA));
    cfg_prescale = 6'd8; cfg_par_en = 1'b0; cfg_par_typ = 1'b1; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("pre-rst busy", 32'(cfg_busy), 32'(1'b1));
    RX_IN = 1'b0; RST = 1'b1;
    tick();
    chk("mid rst m_valid",  32'(m_valid),     32'(1'b0));
    chk("mid rst m_data",   32'(m_data),      32'(8'h00));
    chk("mid rst rx_line",  32'(rx_line),     32'(1'b1));
    chk("mid rst cfg_busy", 32'(cfg_busy),    32'(1'b0));
    chk("mid rst prescale", 32'(rx_prescale), 32'(6'd32));
    chk("mid rst par_en",   32'(rx_par_en),   32'(1'b0));
    chk("mid rst par_typ",  32'(rx_par_typ),  32'(1'b0));
    RST = 1'b0; enable = 1'b0;
    tick();
    tick();
    chk("post rst off gated", 32'(rx_line), 32'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
